fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of write requesters.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8: data width of each requester and of the FIFO write port.
REQ-003 The block SHALL have parameter MAX_BURST, default 4: maximum beats per grant.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port req_valid, input, NUM_REQ bits: bit i set means requester i offers a beat.
REQ-007 The block SHALL have port req_data, input, NUM_REQ*DATA_WIDTH bits: requester i data in slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The block SHALL have port req_ready, output, NUM_REQ bits: bit i set means requester i's beat is accepted this cycle.
REQ-009 The block SHALL have port fifo_full, input, 1 bit: the FIFO full flag.
REQ-010 The block SHALL have port fifo_push, output, 1 bit: FIFO push strobe.
REQ-011 The block SHALL have port fifo_data, output, DATA_WIDTH bits: FIFO write data.
REQ-012 The block SHALL have port grant_id, output, clog2(NUM_REQ) bits: the currently or last granted requester.
REQ-013 The block SHALL have port busy, output, 1 bit: high while in state BURST.
REQ-014 The block SHALL have port stall_cnt, output, 16 bits: saturating count of full-stall cycles.

Function
REQ-015 The block SHALL implement two FSM states, IDLE and BURST.
REQ-016 In IDLE with req_valid nonzero, the block SHALL select the first set bit searching upward from (last_grant+1) mod NUM_REQ.
- The block SHALL register that index into grant_id.
- The block SHALL clear beat_cnt and enter BURST next cycle.
REQ-017 In IDLE, req_ready SHALL be all zero and fifo_push SHALL be 0, so arbitration costs exactly one cycle.
REQ-018 In BURST, req_ready[grant_id] SHALL equal !fifo_full (combinational) and all other req_ready bits SHALL be 0.
REQ-019 The block SHALL assert fifo_push = req_valid[grant_id] && !fifo_full while in BURST.
- fifo_data SHALL be req_data slice of grant_id whenever busy, and 0 otherwise.
- No push SHALL ever be issued while fifo_full=1, so no beat is lost.
REQ-020 Each pushed beat SHALL increment beat_cnt, a clog2(MAX_BURST+1)-bit counter.
REQ-021 BURST SHALL exit to IDLE, with last_grant set to grant_id, when either:
- the push that makes beat_cnt reach MAX_BURST occurs, or
- req_valid[grant_id]=0 in a cycle with no push.
REQ-022 A cycle in BURST with req_valid[grant_id]=1 and fifo_full=1 SHALL increment stall_cnt, saturating at 16'hFFFF.
- Such a cycle SHALL neither exit BURST nor change beat_cnt.
REQ-023 After a MAX_BURST exit with the same requester still the only one valid, it SHALL be re-granted after one IDLE cycle.
- With other requesters valid, round-robin SHALL pass the grant to the next one.
REQ-024 grant_id SHALL hold its value in IDLE until the next grant.

Reset
REQ-025 While rst=1, asynchronously, the block SHALL force:
- state=IDLE, busy=0, grant_id=0, beat_cnt=0, stall_cnt=0
- fifo_push=0, req_ready=0, fifo_data=0
- last_grant=NUM_REQ-1, so requester 0 has first priority.
REQ-026 A reset asserted mid-burst SHALL abandon the burst immediately without pushing, and the first post-reset grant SHALL follow REQ-025 priority.

Verification
REQ-027 The bench SHALL check reset: rst=1 with random req_valid -> fifo_push=0, req_ready=0, busy=0, grant_id=0, stall_cnt=0.
REQ-028 The bench SHALL check a single requester: req_valid=4'b0100 constant, fifo_full=0 -> pattern of 1 IDLE cycle then 4 pushes, repeated; 8 beats in 10 cycles, grant_id=2.
REQ-029 The bench SHALL check round-robin: req_valid=4'b1111 held -> grant order 0,1,2,3,0, 4 beats each, fifo_data matching each slice.
REQ-030 The bench SHALL check a full stall: fifo_full=1 for 3 cycles after beat 2 of a burst -> no push and req_ready=0 during stall, stall_cnt=3, burst resumes and ends after 2 more beats.
REQ-031 The bench SHALL check an early drop: granted requester drops valid after 2 beats -> IDLE next cycle, then next valid requester above it granted.
REQ-032 The bench SHALL check reset mid-burst: rst pulsed during requester 3's burst -> outputs cleared same cycle, and the first grant after release goes to requester 0 when req_valid=4'b1001.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter that grants one of NUM_REQ write
// requesters a burst of up to MAX_BURST beats into a single FIFO write port.
// Arbitration takes one IDLE cycle; beats are never pushed while the FIFO is
// full, and full-stall cycles are counted in a saturating 16-bit counter.
module fifo_wr_arb #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4,
   localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int BW        = $clog2(MAX_BURST + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_push,
   output logic [DATA_WIDTH-1:0]         fifo_data,
   output logic [GW-1:0]                 grant_id,
   output logic                          busy,
   output logic [15:0]                   stall_cnt
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [GW-1:0]   last_grant_q, last_grant_d;
   logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
   logic [15:0]     stall_q, stall_d;

   logic            busy_s;
   logic            cur_valid_s;
   logic            push_s;
   logic [BW-1:0]   beat_inc_s;
   logic            pick_found_s;
   logic [GW-1:0]   pick_idx_s;

   assign busy_s      = (state_q == ST_BURST);
   assign cur_valid_s = req_valid[grant_q];
   assign push_s      = busy_s && cur_valid_s && !fifo_full;
   assign beat_inc_s  = beat_cnt_q + {{(BW-1){1'b0}}, 1'b1};

   // Round-robin pick: first valid requester searching upward from last_grant+1.
   always_comb begin
      int idx;
      idx          = 0;
      pick_found_s = 1'b0;
      pick_idx_s   = {GW{1'b0}};
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx          = (int'(last_grant_q) + k) % NUM_REQ;
         pick_idx_s   = (!pick_found_s && req_valid[idx]) ? GW'(idx) : pick_idx_s;
         pick_found_s = pick_found_s | req_valid[idx];
      end
   end

   // Next-state logic for the IDLE/BURST controller and its counters.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      beat_cnt_d   = beat_cnt_q;
      stall_d      = stall_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_found_s) begin
               grant_d    = pick_idx_s;
               beat_cnt_d = {BW{1'b0}};
               state_d    = ST_BURST;
            end else begin
               state_d    = ST_IDLE;
            end
         end
         ST_BURST: begin
            if (push_s) begin
               beat_cnt_d = beat_inc_s;
               if (beat_inc_s == BW'(MAX_BURST)) begin
                  state_d      = ST_IDLE;
                  last_grant_d = grant_q;
               end else begin
                  state_d      = ST_BURST;
               end
            end else if (!cur_valid_s) begin
               state_d      = ST_IDLE;
               last_grant_d = grant_q;
            end else begin
               // Requester valid but FIFO full: hold position, count the stall.
               if (stall_q != 16'hFFFF) begin
                  stall_d = stall_q + 16'd1;
               end else begin
                  stall_d = stall_q;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and counter registers; reset gives requester 0 first priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         grant_q      <= {GW{1'b0}};
         last_grant_q <= GW'(NUM_REQ - 1);
         beat_cnt_q   <= {BW{1'b0}};
         stall_q      <= 16'h0000;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
         stall_q      <= stall_d;
      end
   end

   // FIFO-side outputs follow the FIFO full flag within the same cycle.
   always_comb begin
      if (busy_s) begin
         fifo_data = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
         if (!fifo_full) begin
            req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
         end else begin
            req_ready = {NUM_REQ{1'b0}};
         end
      end else begin
         fifo_data = {DATA_WIDTH{1'b0}};
         req_ready = {NUM_REQ{1'b0}};
      end
   end

   assign fifo_push = push_s;
   assign grant_id  = grant_q;
   assign busy      = busy_s;
   assign stall_cnt = stall_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: scenario tasks plus a randomized run, all checked against a
// behavioural model of the arbiter kept in plain integer variables.
module tb_fifo_wr_arb;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MB = 4;

   logic            clk;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            fifo_full;
   logic            fifo_push;
   logic [DW-1:0]   fifo_data;
   logic [1:0]      grant_id;
   logic            busy;
   logic [15:0]     stall_cnt;

   int tests_run = 0;
   int tests_failed = 0;

   // behavioural model state
   bit m_burst;
   int m_owner;
   int m_beats;
   int m_last;
   int m_stall;

   // model predictions for the current cycle
   logic            e_push;
   logic [N-1:0]    e_ready;
   logic [DW-1:0]   e_data;
   logic            e_busy;
   logic [1:0]      e_gid;
   logic [15:0]     e_stall;

   fifo_wr_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .fifo_full(fifo_full), .fifo_push(fifo_push),
      .fifo_data(fifo_data), .grant_id(grant_id), .busy(busy),
      .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_burst = 1'b0;
      m_owner = 0;
      m_beats = 0;
      m_last  = N - 1;
      m_stall = 0;
   endtask

   task automatic model_eval();
      e_busy  = m_burst;
      e_gid   = 2'(m_owner);
      e_stall = 16'(m_stall);
      e_push  = m_burst && req_valid[m_owner] && !fifo_full;
      e_ready = (m_burst && !fifo_full) ? N'(1 << m_owner) : '0;
      e_data  = m_burst ? DW'((req_data >> (m_owner * DW)) & ((1 << DW) - 1)) : '0;
   endtask

   task automatic model_advance();
      if (!m_burst) begin
         for (int k = 1; k <= N; k++) begin
            if (req_valid[(m_last + k) % N]) begin
               m_owner = (m_last + k) % N;
               m_beats = 0;
               m_burst = 1'b1;
               break;
            end
         end
      end else if (req_valid[m_owner] && !fifo_full) begin
         m_beats++;
         if (m_beats == MB) begin
            m_burst = 1'b0;
            m_last  = m_owner;
         end
      end else if (!req_valid[m_owner]) begin
         m_burst = 1'b0;
         m_last  = m_owner;
      end else begin
         m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
      end
   endtask

   // advance one clock: model follows the edge, bench returns at the negedge
   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else model_advance();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      fifo_full = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      for (int c = 0; c < 5; c++) begin
         req_valid = N'($urandom);
         req_data  = $urandom;
         fifo_full = 1'($urandom);
         #1;
         tests_run++;
         if ({fifo_push, req_ready, busy, grant_id, stall_cnt, fifo_data} !== '0) begin
            tests_failed++;
            $display("FAIL reset cyc%0d: push=%b ready=%b busy=%b gid=%0d stall=%0d data=%h, all required 0",
                     c, fifo_push, req_ready, busy, grant_id, stall_cnt, fifo_data);
         end
         tick();
      end
      rst = 1'b0;
   endtask

   task automatic test_single();
      int pushes = 0;
      do_reset();
      req_valid = 4'b0100;
      for (int c = 0; c < 10; c++) begin
         req_data = $urandom;
         #1;
         model_eval();
         tests_run++;
         if ({fifo_push, req_ready, fifo_data, busy, grant_id, stall_cnt} !==
             {e_push, e_ready, e_data, e_busy, e_gid, e_stall}) begin
            tests_failed++;
            $display("FAIL single cyc%0d: push=%b ready=%b data=%h busy=%b gid=%0d, required %b %b %h %b %0d",
                     c, fifo_push, req_ready, fifo_data, busy, grant_id, e_push, e_ready, e_data, e_busy, e_gid);
         end
         // one idle cycle followed by four pushes, repeating
         tests_run++;
         if (fifo_push !== ((c % 5) != 0)) begin
            tests_failed++;
            $display("FAIL single_pattern cyc%0d: push=%b required %b", c, fifo_push, (c % 5) != 0);
         end
         if (fifo_push === 1'b1) pushes++;
         tick();
      end
      tests_run++;
      if (pushes != 8 || grant_id !== 2'd2) begin
         tests_failed++;
         $display("FAIL single_total: beats=%0d gid=%0d, required 8 and 2", pushes, grant_id);
      end
   endtask

   task automatic test_round_robin();
      int order[$];
      int pushes = 0;
      do_reset();
      req_valid = 4'b1111;
      for (int c = 0; c < 25; c++) begin
         req_data = $urandom;
         #1;
         model_eval();
         tests_run++;
         if ({fifo_push, req_ready, fifo_data, busy, grant_id, stall_cnt} !==
             {e_push, e_ready, e_data, e_busy, e_gid, e_stall}) begin
            tests_failed++;
            $display("FAIL rr cyc%0d: push=%b ready=%b data=%h busy=%b gid=%0d, required %b %b %h %b %0d",
                     c, fifo_push, req_ready, fifo_data, busy, grant_id, e_push, e_ready, e_data, e_busy, e_gid);
         end
         if (fifo_push === 1'b1) begin
            if (pushes % 4 == 0) order.push_back(int'(grant_id));
            pushes++;
         end
         tick();
      end
      tests_run++;
      if (pushes != 20 || order.size() != 5 || order[0] != 0 || order[1] != 1 ||
          order[2] != 2 || order[3] != 3 || order[4] != 0) begin
         tests_failed++;
         $display("FAIL rr_order: beats=%0d order=%p, required 20 beats order 0,1,2,3,0", pushes, order);
      end
   endtask

   task automatic test_stall();
      int pushes = 0;
      do_reset();
      req_valid = 4'b0001;
      for (int c = 0; c < 9; c++) begin
         req_data  = $urandom;
         fifo_full = (c >= 3 && c <= 5);
         #1;
         model_eval();
         tests_run++;
         if ({fifo_push, req_ready, fifo_data, busy, grant_id, stall_cnt} !==
             {e_push, e_ready, e_data, e_busy, e_gid, e_stall}) begin
            tests_failed++;
            $display("FAIL stall cyc%0d: push=%b ready=%b data=%h busy=%b stall=%0d, required %b %b %h %b %0d",
                     c, fifo_push, req_ready, fifo_data, busy, stall_cnt, e_push, e_ready, e_data, e_busy, e_stall);
         end
         if (c == 8) begin
            tests_run++;
            if (stall_cnt !== 16'd3 || pushes != 4 || busy !== 1'b0) begin
               tests_failed++;
               $display("FAIL stall_end: stall=%0d beats=%0d busy=%b, required 3, 4, 0", stall_cnt, pushes, busy);
            end
         end
         if (fifo_push === 1'b1) pushes++;
         tick();
      end
      fifo_full = 1'b0;
   endtask

   task automatic test_early_drop();
      do_reset();
      for (int c = 0; c < 6; c++) begin
         req_valid = (c < 3) ? 4'b0101 : 4'b0100;
         req_data  = $urandom;
         #1;
         model_eval();
         tests_run++;
         if ({fifo_push, req_ready, fifo_data, busy, grant_id, stall_cnt} !==
             {e_push, e_ready, e_data, e_busy, e_gid, e_stall}) begin
            tests_failed++;
            $display("FAIL drop cyc%0d: push=%b ready=%b data=%h busy=%b gid=%0d, required %b %b %h %b %0d",
                     c, fifo_push, req_ready, fifo_data, busy, grant_id, e_push, e_ready, e_data, e_busy, e_gid);
         end
         if (c == 4) begin
            tests_run++;
            if (busy !== 1'b0) begin
               tests_failed++;
               $display("FAIL drop_idle: busy=%b required 0", busy);
            end
         end
         if (c == 5) begin
            tests_run++;
            if (busy !== 1'b1 || grant_id !== 2'd2) begin
               tests_failed++;
               $display("FAIL drop_next: busy=%b gid=%0d, required 1 and 2", busy, grant_id);
            end
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      req_valid = 4'b1000;
      for (int c = 0; c < 3; c++) begin
         req_data = $urandom;
         #1;
         model_eval();
         tests_run++;
         if ({fifo_push, req_ready, fifo_data, busy, grant_id} !==
             {e_push, e_ready, e_data, e_busy, e_gid}) begin
            tests_failed++;
            $display("FAIL midrst_pre cyc%0d: push=%b ready=%b busy=%b gid=%0d, required %b %b %b %0d",
                     c, fifo_push, req_ready, busy, grant_id, e_push, e_ready, e_busy, e_gid);
         end
         if (c < 2) tick();
      end
      #1;
      rst = 1'b1;
      #1;
      model_reset();
      tests_run++;
      if ({fifo_push, req_ready, busy, grant_id, stall_cnt, fifo_data} !== '0) begin
         tests_failed++;
         $display("FAIL midrst_clear: push=%b ready=%b busy=%b gid=%0d data=%h, all required 0",
                  fifo_push, req_ready, busy, grant_id, fifo_data);
      end
      tick();
      rst = 1'b0;
      req_valid = 4'b1001;
      #1;
      tests_run++;
      if (busy !== 1'b0 || fifo_push !== 1'b0) begin
         tests_failed++;
         $display("FAIL midrst_idle: busy=%b push=%b, required 0 0", busy, fifo_push);
      end
      tick();
      #1;
      tests_run++;
      if (busy !== 1'b1 || grant_id !== 2'd0) begin
         tests_failed++;
         $display("FAIL midrst_grant: busy=%b gid=%0d, required 1 and 0", busy, grant_id);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         req_valid = ($urandom_range(0, 3) == 0) ? N'($urandom) : req_valid;
         if ($urandom_range(0, 15) == 0) req_valid[m_owner] = 1'b0;
         req_data  = $urandom;
         fifo_full = ($urandom_range(0, 9) < 3);
         #1;
         model_eval();
         tests_run++;
         if ({fifo_push, req_ready, fifo_data, busy, grant_id, stall_cnt} !==
             {e_push, e_ready, e_data, e_busy, e_gid, e_stall}) begin
            tests_failed++;
            $display("FAIL random cyc%0d: push=%b ready=%b data=%h busy=%b gid=%0d stall=%0d, required %b %b %h %b %0d %0d",
                     c, fifo_push, req_ready, fifo_data, busy, grant_id, stall_cnt,
                     e_push, e_ready, e_data, e_busy, e_gid, e_stall);
         end
         tick();
      end
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      fifo_full = 1'b0;
      @(negedge clk);
      test_reset();
      test_single();
      test_round_robin();
      test_stall();
      test_early_drop();
      test_reset_mid_burst();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
